// File: rtl/ram_responder.sv
// -----------------------------------------------------------------------------
// ram_responder
//   NoC-attached single-port RAM endpoint. Unpacks read/write requests coming
//   from a depacketizer, executes them on a local 2^ADDR_WIDTH x WIDTH array
//   and returns read data to the requesting node through an in-order,
//   first-word-fall-through response FIFO feeding a packetizer.
//
//   Request word (MSB first): {data, addr, write_en, read_en, src}
//   Response word           : {rdata, NODE}, routed to o_dest_out = src
//
//   A request is only accepted when every response already in flight
//   (read stage + FIFO) plus one more still fits in the FIFO. A stalled
//   downstream therefore throttles requests instead of losing responses.
//
// Ports
//   clk          in   single clock
//   rst          in   asynchronous, active-high reset
//   i_packed_in  in   packed request
//   i_valid_in   in   request valid
//   i_ready_out  out  request accepted on i_valid_in & i_ready_out
//   o_packed_out out  response {rdata, NODE} at FIFO head
//   o_dest_out   out  destination node of the head response
//   o_valid_out  out  head response valid
//   o_ready_in   in   downstream ready; pops the head response
//
// Build option
//   RAM_RESPONDER_WRITE_ACK_EN : when defined, every accepted write also
//   returns a response carrying the written data (or the old data when the
//   same request also reads). When undefined, writes are silent.
// -----------------------------------------------------------------------------

// Run-time checks on the response FIFO occupancy.
module ram_responder_chk #(
  parameter int RESP_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  // Push into a full FIFO or pop from an empty one is a design error
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count == CNT_W'(RESP_DEPTH))))
        else $error("ram_responder: response pushed into full FIFO");
      assert (!(pop && (count == {CNT_W{1'b0}})))
        else $error("ram_responder: response popped from empty FIFO");
    end
  end

endmodule

module ram_responder #(
  parameter int WIDTH        = 8,
  parameter int ADDR_WIDTH   = 7,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NODE         = 1,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [WIDTH+ADDR_WIDTH+N_ADDR_WIDTH+2-1:0] i_packed_in,
  input  logic                                     i_valid_in,
  output logic                                     i_ready_out,
  output logic [WIDTH+N_ADDR_WIDTH-1:0]            o_packed_out,
  output logic [N_ADDR_WIDTH-1:0]                  o_dest_out,
  output logic                                     o_valid_out,
  input  logic                                     o_ready_in
);

  localparam int PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [N_ADDR_WIDTH-1:0] NODE_ID  = N_ADDR_WIDTH'(NODE);
  localparam logic [CNT_W-1:0]        FULL_CNT = CNT_W'(RESP_DEPTH);

  // Request fields
  logic [N_ADDR_WIDTH-1:0] src_s;
  logic                    read_en_s;
  logic                    write_en_s;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [WIDTH-1:0]        data_s;
  logic                    accept_s;
  logic                    respond_s;

  // Storage
  logic [WIDTH-1:0]        mem_r [MEM_DEPTH];

  // Read stage: holds one response between acceptance and FIFO push
  logic                    pipe_valid_r;
  logic [WIDTH-1:0]        pipe_data_r;
  logic [N_ADDR_WIDTH-1:0] pipe_dest_r;

  // Response FIFO
  logic [WIDTH-1:0]        fifo_data_r [RESP_DEPTH];
  logic [N_ADDR_WIDTH-1:0] fifo_dest_r [RESP_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [CNT_W-1:0]        credit_s;
  logic                    not_empty_s;
  logic                    push_s;
  logic                    pop_s;

  // Request field decode and response-generation decision
  always_comb begin
    src_s      = i_packed_in[N_ADDR_WIDTH-1:0];
    read_en_s  = i_packed_in[N_ADDR_WIDTH];
    write_en_s = i_packed_in[N_ADDR_WIDTH+1];
    addr_s     = i_packed_in[N_ADDR_WIDTH+2 +: ADDR_WIDTH];
    data_s     = i_packed_in[N_ADDR_WIDTH+2+ADDR_WIDTH +: WIDTH];
`ifdef RAM_RESPONDER_WRITE_ACK_EN
    respond_s  = read_en_s | write_en_s;
`else
    respond_s  = read_en_s;
`endif
    accept_s   = i_valid_in & i_ready_out;
  end

  // Flow control: credits are counted from registered state only, so the
  // in-flight response in the read stage always has a FIFO slot reserved.
  always_comb begin
    credit_s    = count_r + {{(CNT_W-1){1'b0}}, pipe_valid_r};
    i_ready_out = ~rst & (credit_s < FULL_CNT);
  end

  // FIFO handshake and first-word-fall-through head presentation
  always_comb begin
    not_empty_s = (count_r != {CNT_W{1'b0}});
    push_s      = pipe_valid_r;
    pop_s       = not_empty_s & o_ready_in;
    if (not_empty_s) begin
      o_valid_out  = 1'b1;
      o_packed_out = {fifo_data_r[rd_ptr_r], NODE_ID};
      o_dest_out   = fifo_dest_r[rd_ptr_r];
    end else begin
      o_valid_out  = 1'b0;
      o_packed_out = {(WIDTH+N_ADDR_WIDTH){1'b0}};
      o_dest_out   = {N_ADDR_WIDTH{1'b0}};
    end
  end

  // RAM array and read-stage data capture (not reset). The read samples the
  // array before the write lands, giving read-before-write on a combined
  // request. A write-only request forwards its own data for the optional ack.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      if (read_en_s) begin
        pipe_data_r <= mem_r[addr_s];
      end else begin
        pipe_data_r <= data_s;
      end
      if (write_en_s) begin
        mem_r[addr_s] <= data_s;
      end
    end
  end

  // Read-stage valid and destination
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_r <= 1'b0;
      pipe_dest_r  <= {N_ADDR_WIDTH{1'b0}};
    end else begin
      pipe_valid_r <= accept_s & respond_s;
      if (accept_s) begin
        pipe_dest_r <= src_s;
      end
    end
  end

  // FIFO entry storage (contents are only visible while count is non-zero)
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= pipe_data_r;
      fifo_dest_r[wr_ptr_r] <= pipe_dest_r;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at RESP_DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  ram_responder_chk #(
    .RESP_DEPTH (RESP_DEPTH),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Directed, table-driven bench for ram_responder (default parameters).
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [20:0] i_packed_in = 21'd0;
  logic        i_valid_in = 1'b0;
  logic        i_ready_out;
  logic [11:0] o_packed_out;
  logic [3:0]  o_dest_out;
  logic        o_valid_out;
  logic        o_ready_in = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] node;
    logic [3:0] dest;
    int         cyc;
  } resp_t;
  resp_t got[$];

  typedef struct {
    logic       v;
    logic       re;
    logic       we;
    logic [6:0] a;
    logic [7:0] d;
    logic [3:0] s;
    logic       e_rdy;
    logic       e_v;
    logic [7:0] e_d;
    logic [3:0] e_dst;
  } vec_t;
  vec_t tbl[14];

  int issue[128];

  ram_responder dut (
    .clk          (clk),
    .rst          (rst),
    .i_packed_in  (i_packed_in),
    .i_valid_in   (i_valid_in),
    .i_ready_out  (i_ready_out),
    .o_packed_out (o_packed_out),
    .o_dest_out   (o_dest_out),
    .o_valid_out  (o_valid_out),
    .o_ready_in   (o_ready_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every response that is actually popped (handshake seen mid-cycle)
  always @(negedge clk) begin
    if (!rst && o_valid_out && o_ready_in) begin
      got.push_back('{o_packed_out[11:4], o_packed_out[3:0], o_dest_out, cyc});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic re, input logic we,
                       input logic [6:0] a, input logic [7:0] d, input logic [3:0] s);
    i_valid_in  = v;
    i_packed_in = {d, a, we, re, s};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
  endtask

  initial begin
    int idx;
    int hi;
    int t0;
    logic rdy;

    // ---------------- reset state ----------------
    #1;
    check("rst_valid", {31'd0, o_valid_out}, 32'd0);
    check("rst_packed", {20'd0, o_packed_out}, 32'd0);
    check("rst_dest", {28'd0, o_dest_out}, 32'd0);
    check("rst_ready", {31'd0, i_ready_out}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, i_ready_out}, 32'd1);
    step();

    // ---------------- fill RAM, then stream reads ----------------
    o_ready_in = 1'b1;
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 1'b0, 1'b1, 7'(i), 8'(i), 4'd0);
      step();
    end
    idle();
    repeat (5) step();
    got.delete();
    for (int i = 0; i < 128; i++) begin
      issue[i] = cyc;
      drive(1'b1, 1'b1, 1'b0, 7'(i), 8'd0, 4'd0);
      step();
    end
    idle();
    for (int w = 0; w < 20 && got.size() < 128; w++) step();
    repeat (3) step();
    check("stream_count", got.size(), 32'd128);
    for (int i = 0; i < 128 && i < got.size(); i++) begin
      check($sformatf("stream_data[%0d]", i), {24'd0, got[i].data}, 32'(i));
      check($sformatf("stream_dest[%0d]", i), {28'd0, got[i].dest}, 32'd0);
      check($sformatf("stream_node[%0d]", i), {28'd0, got[i].node}, 32'd1);
      check($sformatf("stream_lat[%0d]", i), got[i].cyc - issue[i], 32'd2);
    end

    // ---------------- table: no-ops and reads ----------------
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 7'd20,  8'h00, 4'd9,  1'b1, 1'b0, 8'h00, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 7'd21,  8'hFF, 4'd2,  1'b1, 1'b0, 8'h00, 4'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 7'd33,  8'h00, 4'd6,  1'b1, 1'b0, 8'h00, 4'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 7'd34,  8'h00, 4'd7,  1'b1, 1'b0, 8'h00, 4'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 7'd0,   8'h00, 4'd0,  1'b1, 1'b1, 8'd33, 4'd6};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 7'd35,  8'h00, 4'd8,  1'b1, 1'b1, 8'd34, 4'd7};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 7'd0,   8'h00, 4'd0,  1'b1, 1'b0, 8'h00, 4'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 7'd127, 8'h00, 4'd15, 1'b1, 1'b0, 8'h00, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 7'd0,   8'h00, 4'd0,  1'b1, 1'b0, 8'h00, 4'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 7'd0,   8'h00, 4'd0,  1'b1, 1'b1, 8'd127, 4'd15};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 7'd0,   8'h00, 4'd0,  1'b1, 1'b0, 8'h00, 4'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 7'd21,  8'h00, 4'd1,  1'b1, 1'b0, 8'h00, 4'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 7'd0,   8'h00, 4'd0,  1'b1, 1'b0, 8'h00, 4'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 7'd0,   8'h00, 4'd0,  1'b1, 1'b1, 8'd21, 4'd1};
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].s);
      check($sformatf("tbl_ready[%0d]", i), {31'd0, i_ready_out}, {31'd0, tbl[i].e_rdy});
      check($sformatf("tbl_valid[%0d]", i), {31'd0, o_valid_out}, {31'd0, tbl[i].e_v});
      if (tbl[i].e_v) begin
        check($sformatf("tbl_packed[%0d]", i), {20'd0, o_packed_out}, {20'd0, tbl[i].e_d, 4'd1});
        check($sformatf("tbl_dest[%0d]", i), {28'd0, o_dest_out}, {28'd0, tbl[i].e_dst});
      end
      step();
    end
    idle();
    repeat (3) step();

    // ---------------- sustained no-op requests ----------------
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 7'(i), 8'(i), 4'(i));
      check($sformatf("noop_ready[%0d]", i), {31'd0, i_ready_out}, 32'd1);
      check($sformatf("noop_valid[%0d]", i), {31'd0, o_valid_out}, 32'd0);
      step();
    end
    idle();
    step();

    // ---------------- back-pressure ----------------
    o_ready_in = 1'b0;
    got.delete();
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 6) drive(1'b1, 1'b1, 1'b0, 7'(3 + idx), 8'd0, 4'(idx));
      else idle();
      rdy = i_ready_out;
      step();
      if (rdy) idx++;
    end
    check("bp_accepts", idx, 32'd4);
    check("bp_ready_low", {31'd0, i_ready_out}, 32'd0);
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (i_ready_out) hi++;
    end
    check("bp_ready_stuck_low", hi, 32'd0);
    check("bp_head_valid", {31'd0, o_valid_out}, 32'd1);
    check("bp_head_data", {20'd0, o_packed_out}, {20'd0, 8'd3, 4'd1});
    o_ready_in = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      drive(1'b1, 1'b1, 1'b0, 7'(3 + idx), 8'd0, 4'(idx));
      rdy = i_ready_out;
      step();
      if (rdy) idx++;
    end
    idle();
    check("bp_all_accepted", idx, 32'd6);
    for (int w = 0; w < 30 && got.size() < 6; w++) step();
    repeat (4) step();
    check("bp_count", got.size(), 32'd6);
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      check($sformatf("bp_data[%0d]", k), {24'd0, got[k].data}, 32'(3 + k));
      check($sformatf("bp_dest[%0d]", k), {28'd0, got[k].dest}, 32'(k));
    end

    // ---------------- read-before-write ----------------
    drive(1'b1, 1'b0, 1'b1, 7'd5, 8'h11, 4'd0);
    step();
    idle();
    repeat (5) step();
    got.delete();
    drive(1'b1, 1'b1, 1'b1, 7'd5, 8'hAA, 4'd7);
    step();
    drive(1'b1, 1'b1, 1'b0, 7'd5, 8'h00, 4'd3);
    step();
    idle();
    repeat (5) step();
    check("rbw_count", got.size(), 32'd2);
    if (got.size() >= 2) begin
      check("rbw_old_data", {24'd0, got[0].data}, 32'h11);
      check("rbw_old_dest", {28'd0, got[0].dest}, 32'd7);
      check("rbw_new_data", {24'd0, got[1].data}, 32'hAA);
      check("rbw_new_dest", {28'd0, got[1].dest}, 32'd3);
    end

    // ---------------- reset with queued responses ----------------
    o_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 7'(40 + k), 8'd0, 4'(k));
      step();
    end
    idle();
    step();
    step();
    check("mid_pre_valid", {31'd0, o_valid_out}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_valid_async", {31'd0, o_valid_out}, 32'd0);
    check("mid_ready_in_rst", {31'd0, i_ready_out}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_ready_still_rst", {31'd0, i_ready_out}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_ready_release", {31'd0, i_ready_out}, 32'd1);
    check("mid_valid_release", {31'd0, o_valid_out}, 32'd0);
    o_ready_in = 1'b1;
    got.delete();
    t0 = cyc;
    drive(1'b1, 1'b1, 1'b0, 7'd77, 8'd0, 4'd9);
    step();
    idle();
    repeat (5) step();
    check("mid_new_count", got.size(), 32'd1);
    if (got.size() >= 1) begin
      check("mid_new_data", {24'd0, got[0].data}, 32'd77);
      check("mid_new_dest", {28'd0, got[0].dest}, 32'd9);
      check("mid_new_lat", got[0].cyc - t0, 32'd2);
    end

    // ---------------- write acknowledge (build option) ----------------
    got.delete();
    t0 = cyc;
    drive(1'b1, 1'b0, 1'b1, 7'd9, 8'h5C, 4'd2);
    step();
    idle();
    repeat (5) step();
`ifdef RAM_RESPONDER_WRITE_ACK_EN
    check("wack_count", got.size(), 32'd1);
    if (got.size() >= 1) begin
      check("wack_data", {24'd0, got[0].data}, 32'h5C);
      check("wack_node", {28'd0, got[0].node}, 32'd1);
      check("wack_dest", {28'd0, got[0].dest}, 32'd2);
      check("wack_lat", got[0].cyc - t0, 32'd2);
    end
`else
    check("wack_silent", got.size(), 32'd0);
`endif
    // Confirm the write landed
    got.delete();
    drive(1'b1, 1'b1, 1'b0, 7'd9, 8'd0, 4'd4);
    step();
    idle();
    repeat (5) step();
    check("wack_readback_count", got.size(), 32'd1);
    if (got.size() >= 1) begin
      check("wack_readback_data", {24'd0, got[0].data}, 32'h5C);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
